instr_decoder_pipe: RTL and testbench

- Registered, handshaked successor to the combinational instruction decoder; sits between program memory fetch and the accumulator/register-file/ALU datapath.
- Decode is generalised to NREG registers with one-hot select, and the opcode and data widths are parametrised.
- Adds sequencing:
  - multi-cycle soft-reset pulse on RST;
  - squash of in-flight fetched words after a jump;
  - illegal-select detection.

---
 rtl/instr_decoder_pipe_if.sv | 39 +++
 rtl/instr_decoder_pipe.sv | 215 +++++++++++++++++++++
 tb/tb_instr_decoder_pipe.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_decoder_pipe_if.sv
// Handshake bundle between fetch, the decoder and the datapath.
// Carries the instruction word in and the registered decoded controls out.
interface instr_decoder_pipe_if #(
   parameter int NREG   = 2,
   parameter int OPC_W  = 6,
   parameter int DATA_W = 8
);
   logic                          in_valid;
   logic                          in_ready;
   logic [NREG+OPC_W+DATA_W-1:0]  cell_data;
   logic                          out_valid;
   logic                          out_ready;
   logic                          soft_rstn;
   logic                          load_en;
   logic                          store_en;
   logic [NREG-1:0]               reg_ce;
   logic [NREG-1:0]               reg_oe;
   logic                          jmpf;
   logic                          jmpb;
   logic                          illegal;
   logic [OPC_W-1:0]              instr_code;
   logic [DATA_W-1:0]             prog_mem_data;

   modport slave (
      input  in_valid, cell_data, out_ready,
      output in_ready, out_valid, soft_rstn,
      output load_en, store_en, reg_ce, reg_oe,
      output jmpf, jmpb, illegal,
      output instr_code, prog_mem_data
   );

   modport master (
      output in_valid, cell_data, out_ready,
      input  in_ready, out_valid, soft_rstn,
      input  load_en, store_en, reg_ce, reg_oe,
      input  jmpf, jmpb, illegal,
      input  instr_code, prog_mem_data
   );
endinterface

// File: rtl/instr_decoder_pipe.sv
// Registered, handshaked instruction decoder with soft-reset and squash.
// Ports: clk, rstn (async, low), bus (slave: word in, controls out).
package instr_pkg;
   localparam int OP_RST  = 1;
   localparam int OP_LD   = 2;
   localparam int OP_ST   = 3;
   localparam int OP_JMPF = 4;
   localparam int OP_JMPB = 5;
endpackage

module instr_decoder_pipe
   import instr_pkg::*;
#(
   parameter int NREG       = 2,
   parameter int OPC_W      = 6,
   parameter int DATA_W     = 8,
   parameter int RST_CYC    = 4,
   parameter int SQUASH_CYC = 2
) (
   input logic                 clk,
   input logic                 rstn,
   instr_decoder_pipe_if.slave bus
);
   localparam int IW   = NREG + OPC_W + DATA_W;
   localparam int MAXC = (RST_CYC > SQUASH_CYC) ?
                         RST_CYC : SQUASH_CYC;
   localparam int CW   = (MAXC < 2) ? 1 : $clog2(MAXC + 1);

   typedef enum logic [1:0] {
      RUN,
      RST_HOLD,
      SQUASH
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            soft_q, soft_d;

   logic [NREG-1:0]   sel;
   logic [OPC_W-1:0]  opc;
   logic [DATA_W-1:0] dat;

   logic is_rst, is_ld, is_st, is_jf, is_jb, is_alu;
   logic sel_ok, bad;
   logic rdy, accept, load;

   logic            ov_q;
   logic            ld_q, st_q, jf_q, jb_q, ill_q;
   logic [NREG-1:0] ce_q, oe_q;
   logic [OPC_W-1:0]  opc_q;
   logic [DATA_W-1:0] dat_q;

   logic            ld_d, st_d, jf_d, jb_d;
   logic [NREG-1:0] ce_d, oe_d;

   assign sel = bus.cell_data[IW-1 -: NREG];
   assign opc = bus.cell_data[OPC_W+DATA_W-1 -: OPC_W];
   assign dat = bus.cell_data[DATA_W-1:0];

   assign is_rst = (opc == OPC_W'(OP_RST));
   assign is_ld  = (opc == OPC_W'(OP_LD));
   assign is_st  = (opc == OPC_W'(OP_ST));
   assign is_jf  = (opc == OPC_W'(OP_JMPF));
   assign is_jb  = (opc == OPC_W'(OP_JMPB));
   assign is_alu = !(is_rst || is_ld || is_st ||
                     is_jf || is_jb);

   // Zero or exactly one bit set.
   assign sel_ok = ((sel & (sel - NREG'(1))) == '0);
   assign bad    = (is_ld || is_st || is_alu) && !sel_ok;

   always_comb begin
      rdy = 1'b0;
      unique case (state_q)
         RUN:      rdy = !ov_q || bus.out_ready;
         RST_HOLD: rdy = 1'b0;
         SQUASH:   rdy = 1'b1;
         default:  rdy = 1'b0;
      endcase
   end

   assign accept = bus.in_valid && rdy;
   // Squashed words complete the handshake but never reach the output.
   assign load   = accept && (state_q == RUN);

   always_comb begin
      ld_d = 1'b0;
      st_d = 1'b0;
      jf_d = 1'b0;
      jb_d = 1'b0;
      ce_d = '0;
      oe_d = '0;
      unique case (1'b1)
         is_rst: ;
         is_ld: begin
            ld_d = 1'b1;
            ce_d = sel;
         end
         is_st: begin
            st_d = 1'b1;
            ce_d = sel;
         end
         is_jf: jf_d = 1'b1;
         is_jb: jb_d = 1'b1;
         default: oe_d = sel;
      endcase
      if (bad) begin
         ce_d = '0;
         oe_d = '0;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      soft_d  = soft_q;
      unique case (state_q)
         RUN: begin
            if (accept && is_rst) begin
               state_d = RST_HOLD;
               cnt_d   = CW'(RST_CYC - 1);
               soft_d  = 1'b0;
            end else if (accept && (is_jf || is_jb) &&
                         (SQUASH_CYC > 0)) begin
               state_d = SQUASH;
               cnt_d   = CW'(SQUASH_CYC);
            end
         end
         RST_HOLD: begin
            if (cnt_q == '0) begin
               state_d = RUN;
               soft_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         SQUASH: begin
            if (accept) begin
               if (cnt_q <= CW'(1)) begin
                  state_d = RUN;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q - CW'(1);
               end
            end
         end
         default: begin
            state_d = RUN;
            cnt_d   = '0;
            soft_d  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= RUN;
         cnt_q   <= '0;
         soft_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         soft_q  <= soft_d;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ov_q  <= 1'b0;
         ld_q  <= 1'b0;
         st_q  <= 1'b0;
         jf_q  <= 1'b0;
         jb_q  <= 1'b0;
         ill_q <= 1'b0;
         ce_q  <= '0;
         oe_q  <= '0;
         opc_q <= '0;
         dat_q <= '0;
      end else if (load) begin
         ov_q  <= 1'b1;
         ld_q  <= ld_d;
         st_q  <= st_d;
         jf_q  <= jf_d;
         jb_q  <= jb_d;
         ill_q <= bad;
         ce_q  <= ce_d;
         oe_q  <= oe_d;
         opc_q <= opc;
         dat_q <= dat;
      end else if (ov_q && bus.out_ready) begin
         // Drop strobes once consumed so stale enables never linger.
         ov_q  <= 1'b0;
         ld_q  <= 1'b0;
         st_q  <= 1'b0;
         jf_q  <= 1'b0;
         jb_q  <= 1'b0;
         ill_q <= 1'b0;
         ce_q  <= '0;
         oe_q  <= '0;
      end
   end

   assign bus.in_ready      = rdy;
   assign bus.out_valid     = ov_q;
   assign bus.soft_rstn     = soft_q;
   assign bus.load_en       = ld_q;
   assign bus.store_en      = st_q;
   assign bus.reg_ce        = ce_q;
   assign bus.reg_oe        = oe_q;
   assign bus.jmpf          = jf_q;
   assign bus.jmpb          = jb_q;
   assign bus.illegal       = ill_q;
   assign bus.instr_code    = opc_q;
   assign bus.prog_mem_data = dat_q;
endmodule

// File: tb/tb_instr_decoder_pipe.sv
// Directed bench for instr_decoder_pipe.
// Drives words through the bus interface and checks decoded controls.
module tb_instr_decoder_pipe;
   import instr_pkg::*;

   logic clk;
   logic rstn;
   int   n_chk;
   int   n_fail;

   instr_decoder_pipe_if #(
      .NREG(2), .OPC_W(6), .DATA_W(8)
   ) bus_if ();

   instr_decoder_pipe #(
      .NREG(2), .OPC_W(6), .DATA_W(8),
      .RST_CYC(4), .SQUASH_CYC(2)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [5:0] LD  = 6'(OP_LD);
   localparam logic [5:0] ST  = 6'(OP_ST);
   localparam logic [5:0] RS  = 6'(OP_RST);
   localparam logic [5:0] JF  = 6'(OP_JMPF);
   localparam logic [5:0] JB  = 6'(OP_JMPB);
   localparam logic [5:0] ALU = 6'h10;

   function automatic logic [15:0] w(
      input logic [1:0] s,
      input logic [5:0] o,
      input logic [7:0] d
   );
      return {s, o, d};
   endfunction

   task automatic chk(
      input string       tag,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [15:0] word);
      bus_if.in_valid  = 1'b1;
      bus_if.cell_data = word;
   endtask

   task automatic idle();
      bus_if.in_valid = 1'b0;
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      rstn   = 1'b0;
      bus_if.in_valid  = 1'b0;
      bus_if.cell_data = '0;
      bus_if.out_ready = 1'b0;
      step();
      step();
      chk("rst_ov",   bus_if.out_valid, 0);
      chk("rst_soft", bus_if.soft_rstn, 1);
      chk("rst_ce",   bus_if.reg_ce, 0);
      chk("rst_oe",   bus_if.reg_oe, 0);
      chk("rst_opc",  bus_if.instr_code, 0);
      chk("rst_dat",  bus_if.prog_mem_data, 0);
      chk("rst_rdy",  bus_if.in_ready, 1);
      rstn = 1'b1;
      step();

      // LD sel=10
      bus_if.out_ready = 1'b1;
      send(w(2'b10, LD, 8'h5A));
      step();
      idle();
      chk("ld_ov",  bus_if.out_valid, 1);
      chk("ld_en",  bus_if.load_en, 1);
      chk("ld_ce",  bus_if.reg_ce, 2'b10);
      chk("ld_oe",  bus_if.reg_oe, 0);
      chk("ld_dat", bus_if.prog_mem_data, 8'h5A);
      chk("ld_ill", bus_if.illegal, 0);
      chk("ld_opc", bus_if.instr_code, LD);
      step();
      chk("ld_drain", bus_if.out_valid, 0);

      // Back-to-back ALU with backpressure
      bus_if.out_ready = 1'b0;
      send(w(2'b01, ALU, 8'h11));
      step();
      send(w(2'b10, ALU, 8'h22));
      chk("bp_rdy0", bus_if.in_ready, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("bp_oe",  bus_if.reg_oe, 2'b01);
         chk("bp_dat", bus_if.prog_mem_data, 8'h11);
         chk("bp_rdy", bus_if.in_ready, 0);
      end
      bus_if.out_ready = 1'b1;
      #1;
      chk("bp_rdy1", bus_if.in_ready, 1);
      step();
      idle();
      chk("bp2_ov",  bus_if.out_valid, 1);
      chk("bp2_oe",  bus_if.reg_oe, 2'b10);
      chk("bp2_dat", bus_if.prog_mem_data, 8'h22);
      step();
      chk("bp_end", bus_if.out_valid, 0);

      // RST hold of 4 cycles
      send(w(2'b00, RS, 8'h00));
      step();
      idle();
      chk("rs_ov", bus_if.out_valid, 1);
      chk("rs_ld", bus_if.load_en, 0);
      for (int i = 0; i < 4; i++) begin
         chk("rs_soft", bus_if.soft_rstn, 0);
         chk("rs_rdy",  bus_if.in_ready, 0);
         step();
      end
      chk("rs_soft1", bus_if.soft_rstn, 1);
      chk("rs_rdy1",  bus_if.in_ready, 1);

      // JMPF then 3 back-to-back words
      send(w(2'b00, JF, 8'h07));
      step();
      chk("jf_ov", bus_if.out_valid, 1);
      chk("jf_jf", bus_if.jmpf, 1);
      send(w(2'b01, ALU, 8'hA1));
      step();
      chk("sq1_ov", bus_if.out_valid, 0);
      send(w(2'b01, ALU, 8'hA2));
      step();
      chk("sq2_ov", bus_if.out_valid, 0);
      send(w(2'b10, ALU, 8'hA3));
      step();
      idle();
      chk("sq3_ov",  bus_if.out_valid, 1);
      chk("sq3_dat", bus_if.prog_mem_data, 8'hA3);
      chk("sq3_oe",  bus_if.reg_oe, 2'b10);
      chk("sq3_jf",  bus_if.jmpf, 0);
      step();

      // JMPB with idle gaps between squashed words
      send(w(2'b00, JB, 8'h09));
      step();
      idle();
      chk("jb_jb", bus_if.jmpb, 1);
      step();
      step();
      chk("gap_ov", bus_if.out_valid, 0);
      send(w(2'b01, ALU, 8'hB1));
      step();
      idle();
      chk("gb1_ov", bus_if.out_valid, 0);
      step();
      step();
      send(w(2'b01, ALU, 8'hB2));
      step();
      chk("gb2_ov", bus_if.out_valid, 0);
      send(w(2'b01, ALU, 8'hB3));
      step();
      idle();
      chk("gb3_ov",  bus_if.out_valid, 1);
      chk("gb3_dat", bus_if.prog_mem_data, 8'hB3);
      step();

      // Illegal selects
      send(w(2'b11, ST, 8'h33));
      step();
      idle();
      chk("ill_ov", bus_if.out_valid, 1);
      chk("ill_f",  bus_if.illegal, 1);
      chk("ill_st", bus_if.store_en, 1);
      chk("ill_ce", bus_if.reg_ce, 0);
      send(w(2'b11, ALU, 8'h44));
      step();
      chk("illa_f",  bus_if.illegal, 1);
      chk("illa_oe", bus_if.reg_oe, 0);
      send(w(2'b00, LD, 8'h55));
      step();
      idle();
      chk("z_ill", bus_if.illegal, 0);
      chk("z_ld",  bus_if.load_en, 1);
      step();

      // Async reset during RST_HOLD with word pending
      bus_if.out_ready = 1'b0;
      send(w(2'b00, RS, 8'h00));
      step();
      idle();
      step();
      chk("mr_soft0", bus_if.soft_rstn, 0);
      chk("mr_ov1",   bus_if.out_valid, 1);
      #2;
      rstn = 1'b0;
      #1;
      chk("mr_soft", bus_if.soft_rstn, 1);
      chk("mr_ov",   bus_if.out_valid, 0);
      chk("mr_ce",   bus_if.reg_ce, 0);
      chk("mr_opc",  bus_if.instr_code, 0);
      step();
      rstn = 1'b1;
      step();
      chk("mr_rdy",  bus_if.in_ready, 1);
      chk("mr_soft1", bus_if.soft_rstn, 1);
      bus_if.out_ready = 1'b1;
      send(w(2'b01, LD, 8'h66));
      step();
      idle();
      chk("mr_ld", bus_if.load_en, 1);
      chk("mr_dat", bus_if.prog_mem_data, 8'h66);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
